fifo_sync_4: RTL and testbench

- 4-entry synchronous FIFO that sits directly upstream of the occupancy-counting stage.
- Stores WIDTH-bit words, tracks occupancy, and generates registered push/pop strobes and full/empty/almost flags.
- Downstream consumers use these signals for flow control.
- Write/read pointers are 2-bit wrapping counters; occupancy is a separate 3-bit count (0..4).

---
 rtl/fifo_sync_4.sv | 154 +++++++++++++++
 tb/tb_fifo_sync_4.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_4.sv
// -----------------------------------------------------------------------------
// fifo_sync_4
//   Four-entry synchronous FIFO. It stores WIDTH-bit words, keeps a registered
//   occupancy count, and produces the flow-control flags and the one-cycle
//   push/pop strobes used by the downstream occupancy-counting stage.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   wr_en        in   1      write request
//   wr_data      in   WIDTH  write data, captured when a write is accepted
//   rd_en        in   1      read request
//   rd_data      out  WIDTH  registered read data (holds when no pop)
//   rd_valid     out  1      one-cycle pulse: rd_data holds a newly popped word
//   count        out  3      occupancy 0..4
//   empty        out  1      count == 0
//   full         out  1      count == 4
//   almost_full  out  1      count == 3
//   almost_empty out  1      count == 1
//   push         out  1      a write was accepted on the previous edge
//   pop          out  1      a read was accepted on the previous edge
//   overflow     out  1      sticky: write requested while full
//   underflow    out  1      sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo_sync_4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic [2:0]       count,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             push,
   output logic             pop,
   output logic             overflow,
   output logic             underflow
);

   // Storage and pointers. The pointers are plain 2-bit counters that wrap
   // naturally; occupancy is tracked separately so full/empty never depend on
   // pointer comparison.
   logic [WIDTH-1:0] mem_r [0:3];
   logic [1:0]       wr_ptr_r;
   logic [1:0]       rd_ptr_r;
   logic [2:0]       count_r;
   logic [2:0]       count_next_s;

   // Output registers.
   logic [WIDTH-1:0] rd_data_r;
   logic             rd_valid_r;
   logic             empty_r;
   logic             full_r;
   logic             almost_full_r;
   logic             almost_empty_r;
   logic             push_r;
   logic             pop_r;
   logic             overflow_r;
   logic             underflow_r;

   // Accept decisions, made only from registered state.
   logic             wr_acc_s;
   logic             rd_acc_s;
   logic             wr_rej_s;
   logic             rd_rej_s;

   // Accept/reject decode from the current registered flags.
   always_comb begin
      wr_acc_s = wr_en & ~full_r;
      rd_acc_s = rd_en & ~empty_r;
      wr_rej_s = wr_en & full_r;
      rd_rej_s = rd_en & empty_r;
   end

   // Next occupancy: simultaneous accepted write and read cancel out.
   always_comb begin
      count_next_s = count_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_next_s = count_r + 3'd1;
         2'b01:   count_next_s = count_r - 3'd1;
         2'b11:   count_next_s = count_r;
         default: count_next_s = count_r;
      endcase
   end

   // Storage write port. Contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (wr_acc_s && !rst) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, count, read data and all status registers.
   // Flags are registered from the next count, which makes them change in the
   // cycle after the accepting edge, exactly like a decode of count itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r       <= 2'd0;
         rd_ptr_r       <= 2'd0;
         count_r        <= 3'd0;
         rd_data_r      <= {WIDTH{1'b0}};
         rd_valid_r     <= 1'b0;
         empty_r        <= 1'b1;
         full_r         <= 1'b0;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b0;
         push_r         <= 1'b0;
         pop_r          <= 1'b0;
         overflow_r     <= 1'b0;
         underflow_r    <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         // Reading the slot being written cannot happen: with 0<count<4 the
         // pointers differ, and at count 0 the read is rejected (no bypass).
         if (rd_acc_s) begin
            rd_ptr_r   <= rd_ptr_r + 2'd1;
            rd_data_r  <= mem_r[rd_ptr_r];
            rd_valid_r <= 1'b1;
         end else begin
            rd_valid_r <= 1'b0;
         end
         count_r        <= count_next_s;
         empty_r        <= (count_next_s == 3'd0);
         full_r         <= (count_next_s == 3'd4);
         almost_full_r  <= (count_next_s == 3'd3);
         almost_empty_r <= (count_next_s == 3'd1);
         push_r         <= wr_acc_s;
         pop_r          <= rd_acc_s;
         overflow_r     <= overflow_r | wr_rej_s;
         underflow_r    <= underflow_r | rd_rej_s;
      end
   end

   assign rd_data      = rd_data_r;
   assign rd_valid     = rd_valid_r;
   assign count        = count_r;
   assign empty        = empty_r;
   assign full         = full_r;
   assign almost_full  = almost_full_r;
   assign almost_empty = almost_empty_r;
   assign push         = push_r;
   assign pop          = pop_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_4.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_4
//   Self-checking bench for fifo_sync_4. A table of per-cycle vectors gives the
//   inputs and the expected status after the edge; a queue model of the FIFO
//   feeds a scoreboard of expected read words that is checked whenever the DUT
//   pulses rd_valid. A short random soak follows the table.
// -----------------------------------------------------------------------------
module tb_fifo_sync_4;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [2:0]       count;
   logic             empty;
   logic             full;
   logic             almost_full;
   logic             almost_empty;
   logic             push;
   logic             pop;
   logic             overflow;
   logic             underflow;

   fifo_sync_4 #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .push         (push),
      .pop          (pop),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic             rst;
      logic             wr;
      logic             rd;
      logic [WIDTH-1:0] data;
      int               cnt;
      logic             e;
      logic             f;
      logic             af;
      logic             ae;
      logic             pu;
      logic             po;
      logic             ov;
      logic             un;
      logic             v;
   } vec_t;

   vec_t vecs[$];

   int total = 0;
   int bad   = 0;

   // Model state.
   logic [WIDTH-1:0] mq[$];      // words currently stored
   logic [WIDTH-1:0] exp_q[$];   // words expected on rd_data
   logic [WIDTH-1:0] last_data;
   logic             m_valid;
   logic             m_push;
   logic             m_pop;
   logic             m_ovf;
   logic             m_unf;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d,
                      input int c, input logic e, input logic f, input logic af, input logic ae,
                      input logic pu, input logic po, input logic ov, input logic un, input logic v);
      vec_t x;
      x.rst = r; x.wr = w; x.rd = rd; x.data = d; x.cnt = c;
      x.e = e; x.f = f; x.af = af; x.ae = ae;
      x.pu = pu; x.po = po; x.ov = ov; x.un = un; x.v = v;
      vecs.push_back(x);
   endtask

   // One clock: drive inputs, advance the model, sample after the edge, and
   // check read data against the scoreboard.
   task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
      logic wacc;
      logic racc;
      @(negedge clk);
      rst = r; wr_en = w; rd_en = rd; wr_data = d;
      if (r) begin
         mq.delete();
         exp_q.delete();
         last_data = '0;
         m_valid = 1'b0; m_push = 1'b0; m_pop = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         wacc = w && (mq.size() < 4);
         racc = rd && (mq.size() > 0);
         if (w && !wacc) m_ovf = 1'b1;
         if (rd && !racc) m_unf = 1'b1;
         if (racc) exp_q.push_back(mq.pop_front());
         if (wacc) mq.push_back(d);
         m_valid = racc; m_push = wacc; m_pop = racc;
      end
      @(posedge clk);
      #1;
      chk("rd_valid", rd_valid, m_valid);
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_read", 1, 0);
         end else begin
            last_data = exp_q.pop_front();
            chk("rd_data", rd_data, last_data);
         end
      end else begin
         chk("rd_data_hold", rd_data, last_data);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      last_data = '0;
      m_valid = 1'b0; m_push = 1'b0; m_pop = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;

      //   rst wr rd data  cnt e f af ae pu po ov un v
      // reset and idle
      add(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // fill
      add(0, 1, 0, 8'h11, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h33, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h44, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      // write while full
      add(0, 1, 0, 8'h55, 4, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      // drain
      add(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1);
      add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1);
      add(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
      // read while empty: rd_data keeps 0x44
      add(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
      // pointer wrap
      add(1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 8'hA1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hB2, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hC3, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);
      add(0, 1, 0, 8'hD4, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hE5, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'hF6, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);
      add(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
      // simultaneous traffic at count 2
      add(0, 1, 0, 8'h61, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h62, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         add(0, 1, 1, 8'h63 + 8'(i), 2, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      // fill, then both while full
      add(0, 1, 0, 8'h69, 3, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      add(0, 1, 0, 8'h6A, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0);
      add(0, 1, 1, 8'h6B, 3, 0, 0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 1, 8'h6C, 3, 0, 0, 1, 0, 1, 1, 1, 0, 1);
      // reset mid-burst
      add(1, 1, 1, 8'h6D, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // both while empty: write only, no bypass, underflow
      add(0, 1, 1, 8'h77, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0);
      add(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1);
      add(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].wr, vecs[k].rd, vecs[k].data);
         chk($sformatf("v%0d.count", k),        count,        vecs[k].cnt);
         chk($sformatf("v%0d.empty", k),        empty,        vecs[k].e);
         chk($sformatf("v%0d.full", k),         full,         vecs[k].f);
         chk($sformatf("v%0d.almost_full", k),  almost_full,  vecs[k].af);
         chk($sformatf("v%0d.almost_empty", k), almost_empty, vecs[k].ae);
         chk($sformatf("v%0d.push", k),         push,         vecs[k].pu);
         chk($sformatf("v%0d.pop", k),          pop,          vecs[k].po);
         chk($sformatf("v%0d.overflow", k),     overflow,     vecs[k].ov);
         chk($sformatf("v%0d.underflow", k),    underflow,    vecs[k].un);
         chk($sformatf("v%0d.rd_valid", k),     rd_valid,     vecs[k].v);
      end
      chk("table_scoreboard_empty", exp_q.size(), 0);

      // Random soak against the queue model, with an occasional reset.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
         chk("soak.count",     count,     mq.size());
         chk("soak.empty",     empty,     (mq.size() == 0) ? 1 : 0);
         chk("soak.full",      full,      (mq.size() == 4) ? 1 : 0);
         chk("soak.push",      push,      m_push);
         chk("soak.pop",       pop,       m_pop);
         chk("soak.overflow",  overflow,  m_ovf);
         chk("soak.underflow", underflow, m_unf);
      end
      chk("soak_scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
